fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core; replaces the single fetch-to-decode pipeline register with a DEPTH-entry prefetch FIFO.
- Owns the fetch PC, drives the zero-latency instruction memory, and buffers {instr, pc, pc+4} tuples for the decode stage.
- Takes execute-stage redirects (branch/jal/jalr) and decode stalls.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  fetch address to instruction memory; equals the fetch PC.
- imem_rdata  in  XLEN  instruction word, combinational from imem_addr.
- redirect_valid  in  1  execute-stage PC redirect.
- redirect_pc  in  XLEN  redirect target.
- deq_ready  in  1  decode accepts the head entry (= !StallD).
- deq_valid  out  1  head entry valid.
- deq_instr  out  XLEN  head instruction.
- deq_pc  out  XLEN  head PC.
- deq_pcplus4  out  XLEN  head PC + 4.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst low, async): fetch_pc = RESET_PC, rd_ptr = wr_ptr = 0, count = 0, deq_valid = 0. deq_instr, deq_pc and deq_pcplus4 read 0.
- Storage: circular buffer with log2(DEPTH)-bit pointers; pointers wrap modulo DEPTH.
- deq_fire = deq_valid & deq_ready.
- enq_ok = (count < DEPTH) | deq_fire. A full queue accepts a new word in the same cycle it dequeues.
- Normal cycle (redirect_valid = 0):
  - When enq_ok: write {imem_rdata, fetch_pc, fetch_pc+4} at wr_ptr, advance wr_ptr, fetch_pc += 4.
  - When deq_fire: advance rd_ptr.
  - count += enq - deq; simultaneous enq and deq leaves count unchanged.
  - When full with no deq_fire: fetch_pc holds and no write occurs.
- Redirect (redirect_valid = 1): highest priority.
  - At the edge: fetch_pc = redirect_pc, both pointers = 0, count = 0.
  - No enqueue that cycle.
  - A deq_fire in the same cycle is allowed; the queue still clears, and decode is flushed by the hazard unit.
  - The first post-redirect entry is fetched from redirect_pc on the following cycle.
- Latency (base build): a word fetched in cycle N is visible on deq_* in cycle N+1 at the earliest. deq_valid = (count != 0).
- deq_* outputs are combinational from the entry at rd_ptr.
- Arithmetic: all PC additions are modulo 2^XLEN. fetch_pc = 0xFFFFFFFC wraps to 0 (XLEN = 32).
- redirect_pc is used as given; alignment is checked elsewhere.
- Reset mid-operation clears all state immediately, regardless of clock.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count == 0 and redirect_valid = 0, deq_valid = 1 and deq_* present {imem_rdata, fetch_pc, fetch_pc+4} combinationally in the same cycle.
  - If deq_ready = 1, the word is consumed without being written: pointers unchanged, fetch_pc += 4.
  - If deq_ready = 0, the word is enqueued normally.
  - Zero-cycle fetch-to-decode latency when empty.
- Undefined: deq_valid = (count != 0) only, with minimum latency 1 cycle as above.

Test Plan:
- Reset, then deq_ready = 1 held; imem returns addr^0xA5A5 -> deq_valid from cycle 1; deq_pc sequence 0, 4, 8, 12; deq_pcplus4 = deq_pc + 4; count stays 1.
- deq_ready = 0 for 6 cycles, DEPTH = 4 -> count reaches 4 after 4 cycles; imem_addr freezes at 0x10. Release -> entries 0x0, 0x4, 0x8, 0xC, 0x10 in order, no loss or duplication.
- Full queue, deq_ready = 1 for one cycle -> one dequeue and one enqueue together; count stays 4, imem_addr advances 0x10 -> 0x14.
- redirect_valid = 1 with redirect_pc = 0x200 while count = 3 -> next cycle count = 0, deq_valid = 0, imem_addr = 0x200; following cycle deq_pc = 0x200.
- Simultaneous redirect and deq_fire at count = 2 -> queue cleared to 0, no stale entry appears after redirect.
- rst pulsed low asynchronously mid-burst (count = 2, fetch_pc = 0x40) -> outputs clear before the next edge; fetch restarts at RESET_PC. With FETCH_QUEUE_BYPASS_EN defined: deq_valid = 1 with deq_pc = 0 in the first cycle after reset release.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-queue bus (instruction memory, execute redirect, decode handshake)
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic [XLEN-1:0] imem_addr, imem_rdata, redirect_pc, deq_instr, deq_pc, deq_pcplus4;
  logic redirect_valid, deq_ready, deq_valid;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master(
    output imem_addr, deq_valid, deq_instr, deq_pc, deq_pcplus4, count,
    input  imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
  modport slave(
    input  imem_addr, deq_valid, deq_instr, deq_pc, deq_pcplus4, count,
    output imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner plus DEPTH-entry prefetch FIFO of {instr, pc, pc+4} for decode.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency empty-queue bypass to decode.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] instrMem [DEPTH];
  logic [XLEN-1:0] pcMem [DEPTH];
  logic [XLEN-1:0] pc4Mem [DEPTH];
  logic [XLEN-1:0] fetchPc, fetchPc4;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] cnt;
  logic empty, full, bypass, deqValid, deqFire, enq, deq;
  assign fetchPc4 = fetchPc + XLEN'(4);
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rst & empty & ~bus.redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  assign deqValid = ~empty | bypass;
  assign deqFire = deqValid & bus.deq_ready;
  // A bypassed word taken by decode is never written into the queue
  assign enq = ~bus.redirect_valid & (~full | deqFire) & ~(bypass & bus.deq_ready);
  assign deq = deqFire & ~bypass;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc <= RESET_PC;
      rdPtr <= '0;
      wrPtr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i] <= '0;
        pcMem[i] <= '0;
        pc4Mem[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      fetchPc <= bus.redirect_pc;
      rdPtr <= '0;
      wrPtr <= '0;
      cnt <= '0;
    end else begin
      if (enq) begin
        instrMem[wrPtr] <= bus.imem_rdata;
        pcMem[wrPtr] <= fetchPc;
        pc4Mem[wrPtr] <= fetchPc4;
        wrPtr <= wrPtr + PW'(1);
      end
      if (enq | (bypass & bus.deq_ready)) fetchPc <= fetchPc4;
      if (deq) rdPtr <= rdPtr + PW'(1);
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end
  assign bus.imem_addr = fetchPc;
  assign bus.count = cnt;
  assign bus.deq_valid = deqValid;
  assign bus.deq_instr = bypass ? bus.imem_rdata : instrMem[rdPtr];
  assign bus.deq_pc = bypass ? fetchPc : pcMem[rdPtr];
  assign bus.deq_pcplus4 = bypass ? fetchPc4 : pc4Mem[rdPtr];
endmodule
